// File: rtl/urng_stream_checker_pkg.sv
// Shared types and sizing helpers for the URNG stream checker.
package urng_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      EVAL  = 2'd3
   } state_t;

   // Width of the ones counter: 32 bits per word times 2^log2Samples words,
   // plus one bit of headroom so a window of all-ones words still fits.
   function automatic int countWidth(input int log2Samples);
      return log2Samples + 6;
   endfunction

   // Ideal ones count for a window: half of 32 * 2^log2Samples bits.
   function automatic int expectedCount(input int log2Samples);
      return 1 << (log2Samples + 4);
   endfunction

endpackage

// File: rtl/urng_stream_checker_popcount_reg.sv
// Registered population count of one sample word, with a valid strobe
// that follows the sample-enable by one clock.
module popcount_reg #(
   parameter int WIDTH = 32,
   parameter int PW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_ce,
   input  logic [WIDTH-1:0] i_data,
   output logic [PW-1:0]    o_count,
   output logic             o_valid
);

   logic [PW-1:0] w_count;
   logic [PW-1:0] r_count;
   logic          r_valid;

   // Count the set bits of the incoming word.
   always_comb begin
      w_count = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_count = w_count + PW'(i_data[i]);
      end
   end

   // Capture the count for accepted words; valid marks the cycle it is usable.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= i_ce;
         if (i_ce) begin
            r_count <= w_count;
         end
      end
   end

   assign o_count = r_count;
   assign o_valid = r_valid;

endmodule

// File: rtl/urng_stream_checker.sv
// Reader-side health checker for the Tausworthe URNG word stream: monobit
// count, longest identical-word run and all-zero detection over a window.
module urng_stream_checker
   import urng_pkg::*;
#(
   parameter int WIDTH        = 32,
   parameter int LOG2_SAMPLES = 10,
   parameter int TOL          = 256,
   parameter int REPEAT_MAX   = 4
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  start,
   input  logic                                  ce,
   input  logic [WIDTH-1:0]                      tausrand,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  pass,
   output logic [countWidth(LOG2_SAMPLES)-1:0]   ones_count,
   output logic [7:0]                            max_run,
   output logic                                  repeat_flag,
   output logic                                  zero_flag
);

   localparam int CW       = countWidth(LOG2_SAMPLES);
   localparam int PW       = $clog2(WIDTH + 1);
   localparam int EXPECTED = expectedCount(LOG2_SAMPLES);

   state_t                    r_state;
   state_t                    w_stateNext;
   logic                      w_startAccept;
   logic                      w_accept;
   logic                      w_lastSample;
   logic [LOG2_SAMPLES-1:0]   r_sampleCount;
   logic [WIDTH-1:0]          r_prev;
   logic                      r_prevValid;
   logic [7:0]                r_run;
   logic [7:0]                w_runNext;
   logic [7:0]                w_maxRunNext;
   logic [7:0]                r_maxRun;
   logic [CW-1:0]             r_onesCount;
   logic                      r_zeroFlag;
   logic                      r_pass;
   logic                      r_evalSeen;
   logic                      r_done;
   logic                      r_busy;
   logic [PW-1:0]             w_popCount;
   logic                      w_popValid;
   logic signed [CW:0]        w_deviation;
   logic [CW:0]               w_absDeviation;
   logic                      w_monobitOk;
   logic                      w_repeatFlag;

   // A new window may only start once the previous one has fully reported.
   assign w_startAccept = (r_state == IDLE) && start && !r_busy;
   assign w_accept      = (r_state == ACCUM) && ce;
   assign w_lastSample  = w_accept && (r_sampleCount == '1);
   assign w_repeatFlag  = (r_maxRun >= 8'(REPEAT_MAX));

   popcount_reg #(
      .WIDTH (WIDTH),
      .PW    (PW)
   ) u_popcount (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_ce    (w_accept),
      .i_data  (tausrand),
      .o_count (w_popCount),
      .o_valid (w_popValid)
   );

   // Window sequencing: collect samples, drain the popcount stage, evaluate.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE:    if (w_startAccept) w_stateNext = ACCUM;
         ACCUM:   if (w_lastSample)  w_stateNext = DRAIN;
         DRAIN:   w_stateNext = EVAL;
         EVAL:    w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   // Run length of the current sample and the updated maximum, saturating at 255.
   always_comb begin
      w_runNext = 8'd1;
      if (r_prevValid && (tausrand == r_prev)) begin
         w_runNext = (r_run == 8'hFF) ? 8'hFF : r_run + 8'd1;
      end
      w_maxRunNext = (w_runNext > r_maxRun) ? w_runNext : r_maxRun;
   end

   // Signed distance of the ones count from the ideal half-of-all-bits value.
   always_comb begin
      w_deviation = $signed({1'b0, r_onesCount}) - $signed((CW + 1)'(EXPECTED));
      if (w_deviation < 0) begin
         w_absDeviation = $unsigned(-w_deviation);
      end else begin
         w_absDeviation = $unsigned(w_deviation);
      end
      w_monobitOk = (w_absDeviation <= (CW + 1)'(TOL));
   end

   // State register plus the delayed done pulse and busy window.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_evalSeen <= 1'b0;
         r_done     <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_evalSeen <= (r_state == EVAL);
         r_done     <= r_evalSeen;
         if (w_startAccept) begin
            r_busy <= 1'b1;
         end else if (r_evalSeen) begin
            r_busy <= 1'b0;
         end
      end
   end

   // Per-window statistics, cleared when a new window is accepted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_onesCount   <= '0;
         r_maxRun      <= '0;
         r_zeroFlag    <= 1'b0;
         r_sampleCount <= '0;
         r_run         <= '0;
         r_prev        <= '0;
         r_prevValid   <= 1'b0;
      end else if (w_startAccept) begin
         r_onesCount   <= '0;
         r_maxRun      <= '0;
         r_zeroFlag    <= 1'b0;
         r_sampleCount <= '0;
         r_run         <= '0;
         r_prev        <= '0;
         r_prevValid   <= 1'b0;
      end else begin
         if (w_popValid) begin
            r_onesCount <= r_onesCount + CW'(w_popCount);
         end
         if (w_accept) begin
            r_sampleCount <= r_sampleCount + 1'b1;
            r_run         <= w_runNext;
            r_maxRun      <= w_maxRunNext;
            r_prev        <= tausrand;
            r_prevValid   <= 1'b1;
            if (tausrand == '0) begin
               r_zeroFlag <= 1'b1;
            end
         end
      end
   end

   // Verdict is formed once the final popcount has landed in the counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pass <= 1'b0;
      end else if (w_startAccept) begin
         r_pass <= 1'b0;
      end else if (r_state == EVAL) begin
         r_pass <= w_monobitOk && !w_repeatFlag && !r_zeroFlag;
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign pass        = r_pass;
   assign ones_count  = r_onesCount;
   assign max_run     = r_maxRun;
   assign repeat_flag = w_repeatFlag;
   assign zero_flag   = r_zeroFlag;

endmodule

// File: tb/tb_urng_stream_checker.sv
// Self-checking bench for urng_stream_checker with a 4-word window.
module tb_urng_stream_checker;

   localparam int WIDTH  = 32;
   localparam int LOG2   = 2;
   localparam int TOL    = 4;
   localparam int REPMAX = 4;
   localparam int CW     = LOG2 + 6;
   localparam int NS     = 1 << LOG2;
   localparam int IDEAL  = 64;

   typedef struct packed {
      logic [7:0] ones;
      logic [7:0] maxRun;
      logic       repeatFlag;
      logic       zeroFlag;
      logic       pass;
   } result_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic             ce;
   logic [WIDTH-1:0] tausrand;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CW-1:0]    ones_count;
   logic [7:0]       max_run;
   logic             repeat_flag;
   logic             zero_flag;

   result_t          expQ[$];
   int               checkCount = 0;
   int               errorCount = 0;
   logic [31:0]      s [NS];

   urng_stream_checker #(
      .WIDTH        (WIDTH),
      .LOG2_SAMPLES (LOG2),
      .TOL          (TOL),
      .REPEAT_MAX   (REPMAX)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .ce          (ce),
      .tausrand    (tausrand),
      .busy        (busy),
      .done        (done),
      .pass        (pass),
      .ones_count  (ones_count),
      .max_run     (max_run),
      .repeat_flag (repeat_flag),
      .zero_flag   (zero_flag)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drive one window; the reference result is computed here and queued.
   task automatic applyStimulus(input logic [31:0] smp [NS], input int gapMax, input int midStart);
      result_t e;
      int      ones;
      int      run;
      int      mr;
      int      dev;
      logic    zero;
      ones = 0;
      run  = 0;
      mr   = 0;
      zero = 1'b0;
      for (int i = 0; i < NS; i++) begin
         ones += $countones(smp[i]);
         if (i > 0 && smp[i] == smp[i-1]) run++;
         else run = 1;
         if (run > mr) mr = run;
         if (smp[i] == 32'h0) zero = 1'b1;
      end
      dev = ones - IDEAL;
      if (dev < 0) dev = -dev;
      e.ones       = 8'(ones);
      e.maxRun     = 8'(mr);
      e.repeatFlag = (mr >= REPMAX);
      e.zeroFlag   = zero;
      e.pass       = (dev <= TOL) && (mr < REPMAX) && !zero;
      expQ.push_back(e);

      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("busyAfterStart", busy, 1);
      checkOutput("onesClearedOnStart", ones_count, 0);
      checkOutput("maxRunClearedOnStart", max_run, 0);
      checkOutput("passClearedOnStart", pass, 0);
      for (int i = 0; i < NS; i++) begin
         repeat ($urandom_range(0, gapMax)) begin
            ce       = 1'b0;
            tausrand = $urandom;
            tick();
         end
         ce       = 1'b1;
         tausrand = smp[i];
         start    = (i == midStart);
         tick();
      end
      ce       = 1'b0;
      start    = 1'b0;
      tausrand = $urandom;
   endtask

   // Wait (bounded) for done, then compare the DUT results with the queue head.
   task automatic waitForResult(input string name);
      int      lat;
      result_t e;
      lat = 0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (done === 1'b1) begin
            lat = c;
            break;
         end
      end
      if (expQ.size() > 0) e = expQ.pop_front();
      if (lat == 0) begin
         checkOutput({name, ".doneTimeout"}, done, 1);
      end else begin
         checkOutput({name, ".doneLatency"}, lat, 3);
         checkOutput({name, ".busyAtDone"}, busy, 0);
         checkOutput({name, ".onesCount"}, ones_count, e.ones);
         checkOutput({name, ".maxRun"}, max_run, e.maxRun);
         checkOutput({name, ".repeatFlag"}, repeat_flag, e.repeatFlag);
         checkOutput({name, ".zeroFlag"}, zero_flag, e.zeroFlag);
         checkOutput({name, ".pass"}, pass, e.pass);
         tick();
         checkOutput({name, ".donePulseWidth"}, done, 0);
         checkOutput({name, ".onesHeld"}, ones_count, e.ones);
         checkOutput({name, ".passHeld"}, pass, e.pass);
      end
   endtask

   initial begin
      int doneSeen;
      rst_n    = 1'b0;
      start    = 1'b0;
      ce       = 1'b0;
      tausrand = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      checkOutput("reset.busy", busy, 0);
      checkOutput("reset.done", done, 0);
      checkOutput("reset.pass", pass, 0);
      checkOutput("reset.onesCount", ones_count, 0);
      checkOutput("reset.maxRun", max_run, 0);

      $display("[TB] monobit pass");
      s = '{32'hFFFF0000, 32'h0000FFFF, 32'hFFFF0000, 32'h0000FFFF};
      applyStimulus(s, 0, -1);
      waitForResult("monobitPass");

      $display("[TB] repeated all-ones words");
      s = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      applyStimulus(s, 0, -1);
      waitForResult("repeatOnes");

      $display("[TB] first sample of a window is not a repeat");
      s = '{32'hFFFFFFFF, 32'hFFFF0000, 32'h0000FF00, 32'h000000FF};
      applyStimulus(s, 0, -1);
      waitForResult("firstNotRepeat");

      $display("[TB] short runs");
      s = '{32'hFFFF0000, 32'hFFFF0000, 32'h0000FFFF, 32'h0000FFFF};
      applyStimulus(s, 0, -1);
      waitForResult("runTwo");

      $display("[TB] run one below the repeat limit");
      s = '{32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'hF0F0F0F0};
      applyStimulus(s, 0, -1);
      waitForResult("runThree");

      $display("[TB] upper tolerance edge with ce gaps");
      s = '{32'hFFFF0000, 32'h0000FFFF, 32'hFFFF0000, 32'h000FFFFF};
      applyStimulus(s, 3, -1);
      waitForResult("ones68");
      s = '{32'hFFFF0000, 32'h0000FFFF, 32'hFFFF0000, 32'h001FFFFF};
      applyStimulus(s, 3, -1);
      waitForResult("ones69");

      $display("[TB] lower tolerance edge with ce gaps");
      s = '{32'hFFFF0000, 32'h0000FFFF, 32'hFFFF0000, 32'h00000FFF};
      applyStimulus(s, 2, -1);
      waitForResult("ones60");
      s = '{32'hFFFF0000, 32'h0000FFFF, 32'hFFFF0000, 32'h000007FF};
      applyStimulus(s, 2, -1);
      waitForResult("ones59");

      $display("[TB] zero word with start asserted mid-window");
      s = '{32'h00000000, 32'hFFFFFFFF, 32'hFFFF0000, 32'h0000FFFF};
      applyStimulus(s, 1, 1);
      waitForResult("zeroWord");

      $display("[TB] reset in the middle of a window");
      start = 1'b1;
      tick();
      start = 1'b0;
      ce       = 1'b1;
      tausrand = 32'hFFFFFFFF;
      tick();
      tick();
      ce    = 1'b0;
      rst_n = 1'b0;
      tick();
      checkOutput("midReset.busy", busy, 0);
      checkOutput("midReset.done", done, 0);
      checkOutput("midReset.pass", pass, 0);
      checkOutput("midReset.onesCount", ones_count, 0);
      checkOutput("midReset.maxRun", max_run, 0);
      checkOutput("midReset.zeroFlag", zero_flag, 0);
      checkOutput("midReset.repeatFlag", repeat_flag, 0);
      rst_n    = 1'b1;
      doneSeen = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (done === 1'b1) doneSeen++;
      end
      checkOutput("midReset.noDone", doneSeen, 0);
      checkOutput("midReset.onesStillZero", ones_count, 0);

      $display("[TB] normal window after reset");
      s = '{32'hFFFF0000, 32'h0000FFFF, 32'hFFFF0000, 32'h0000FFFF};
      applyStimulus(s, 1, -1);
      waitForResult("afterReset");

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/urng_stream_checker.md
Name: urng_stream_checker

Overview:
- Reader-side companion to the Tausworthe URNG. Consumes the 32-bit random word stream, qualified by the same `ce` strobe that advances the generator.
- Over a window of 2^LOG2_SAMPLES words it computes:
  - the total count of one bits (monobit test);
  - the longest run of identical consecutive words;
  - whether an all-zero word occurred.
- Reports pass/fail under a start/busy/done handshake. Used in bring-up and in the built-in self-test of the noise-generation path.

Parameters:
- WIDTH, 32: sample word width.
- LOG2_SAMPLES, 10: window length is 2^LOG2_SAMPLES accepted samples.
- TOL, 256: allowed absolute deviation of the ones count from half of all bits.
- REPEAT_MAX, 4: this many identical consecutive samples sets repeat_flag.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin a window; accepted only in IDLE.
- ce  in  1  sample valid; same strobe that advances the URNG.
- tausrand  in  WIDTH  random word under test.
- busy  out  1  high from the cycle after start is accepted until EVAL completes.
- done  out  1  one-cycle pulse when results are valid.
- pass  out  1  monobit within tolerance, repeat_flag=0, zero_flag=0.
- ones_count  out  LOG2_SAMPLES+6  total ones over the window.
- max_run  out  8  longest identical-word run, saturating at 255.
- repeat_flag  out  1  max_run >= REPEAT_MAX.
- zero_flag  out  1  an accepted sample equalled 0.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state goes to IDLE;
  - all outputs and counters clear to 0;
  - this applies mid-window as well; the partial window is discarded and done is not pulsed.
- States: IDLE, ACCUM, DRAIN, EVAL.
- IDLE:
  - start=1 clears ones_count, max_run, the flags, pass, the sample counter, the run counter and prev_valid.
  - Next state is ACCUM.
  - Results from the previous window are held until the next start.
- ACCUM:
  - Each cycle with ce=1 accepts tausrand.
  - Popcount is registered in stage 1 and added to ones_count the following cycle.
  - Run tracking:
    - if prev_valid and tausrand == prev, run = run+1; otherwise run = 1;
    - max_run = max(max_run, run), saturating at 255;
    - prev = tausrand; prev_valid = 1.
  - zero_flag sets if tausrand == 0.
  - ce=0 stalls all accumulation; there is no timeout.
  - The sample counter wraps at 2^LOG2_SAMPLES. When the last sample is accepted, next state is DRAIN.
- DRAIN: one cycle in which the final registered popcount is added. Input ce is ignored.
- EVAL: one cycle.
  - pass = (|ones_count - 2^(LOG2_SAMPLES+4)| <= TOL) and not repeat_flag and not zero_flag.
  - The deviation uses signed arithmetic one bit wider than ones_count.
  - Next state is IDLE.
- Latency: if the last sample is accepted at edge N, then DRAIN is N+1, EVAL is N+2, and done=1 with busy=0 and final results valid during the cycle after edge N+3.
- start while busy is ignored.
- start in the same cycle as done is accepted; results clear at the next edge.
- ce outside ACCUM is ignored.
- repeat_flag is evaluated continuously from max_run.
- The first sample of a window never counts as a repeat.

Decomposition:
- Package urng_pkg holds:
  - the state enum (IDLE/ACCUM/DRAIN/EVAL);
  - localparam functions for the expected count, 2^(LOG2_SAMPLES+4);
  - the count width, LOG2_SAMPLES+6.
- One sub-module, popcount_reg: a WIDTH-bit registered population count with ce-qualified valid out.

Test Plan:
All scenarios use LOG2_SAMPLES=2 (expected count 64), TOL=4 and REPEAT_MAX=4 unless stated.

1. Reset: hold rst_n=0 for 3 cycles, then release. Required: busy=0, done=0, pass=0, ones_count=0, max_run=0.
2. Monobit pass: start, then samples 0xFFFF0000, 0x0000FFFF, 0xFFFF0000, 0x0000FFFF on consecutive ce cycles. Required: ones_count=64, max_run=1, pass=1, done exactly 3 edges after the 4th sample, one cycle wide.
3. Repeat and monobit fail: four samples of 0xFFFFFFFF. Required: ones_count=128, max_run=4, repeat_flag=1, pass=0.
4. Tolerance boundary and ce gaps: samples giving 68 ones pass=1; samples giving 69 ones pass=0. Insert ce=0 gaps with garbage on tausrand; the garbage is ignored.
5. Zero word and control:
   - one sample of 0x00000000 gives zero_flag=1 and pass=0;
   - start asserted during ACCUM has no effect;
   - rst_n=0 after 2 samples gives IDLE, no done, and all outputs 0.
